// File: rtl/controle_pkg.sv
// Shared definitions for the multicycle control unit and the ALU it drives:
// FSM states, opcode/funct fields, ALU operation codes and datapath mux encodings.
package controle_pkg;

    typedef enum logic [3:0] {
        S_RESET,
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTE,
        ALUWB,
        BRANCH,
        ADDIEXEC,
        ADDIWB,
        JUMP
    } state_t;

    // ALUOp chosen by the FSM; FUNCT defers the choice to the R-type funct field
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ULA_ADD = 3'b000;
    localparam logic [2:0] ULA_SUB = 3'b001;
    localparam logic [2:0] ULA_AND = 3'b010;
    localparam logic [2:0] ULA_OR  = 3'b011;
    localparam logic [2:0] ULA_SLT = 3'b101;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/unidade_controle_if.sv
// Control bundle between the control unit (master) and the IR/datapath/ALU side (slave).
interface unidade_controle_if;

    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Z;
    logic [2:0] UlaControl;
    logic       UlaSrcA;
    logic [1:0] UlaSrcB;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       Ilegal;

    modport master (
        input  Op, Funct, Z,
        output UlaControl, UlaSrcA, UlaSrcB, PCSrc, PCEn, IorD,
               MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, Ilegal
    );

    modport slave (
        output Op, Funct, Z,
        input  UlaControl, UlaSrcA, UlaSrcB, PCSrc, PCEn, IorD,
               MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, Ilegal
    );

endinterface

// File: rtl/ula_decoder.sv
// Combinational ALU decoder: maps ALUOp plus the R-type funct field to an ALU code.
// An unknown funct yields ADD and raises funct_illegal so the FSM can abort the write-back.
module ula_decoder
    import controle_pkg::*;
(
    input  aluop_t     alu_op,
    input  logic [5:0] funct,
    output logic [2:0] ula_control,
    output logic       funct_illegal
);

    always_comb begin
        ula_control   = ULA_ADD;
        funct_illegal = 1'b0;
        unique case (alu_op)
            ALUOP_ADD: ula_control = ULA_ADD;
            ALUOP_SUB: ula_control = ULA_SUB;
            ALUOP_FUNCT: begin
                unique case (funct)
                    FUNCT_ADD: ula_control = ULA_ADD;
                    FUNCT_SUB: ula_control = ULA_SUB;
                    FUNCT_AND: ula_control = ULA_AND;
                    FUNCT_OR:  ula_control = ULA_OR;
                    FUNCT_SLT: ula_control = ULA_SLT;
                    default:   funct_illegal = 1'b1;
                endcase
            end
            default: ula_control = ULA_ADD;
        endcase
    end

endmodule

// File: rtl/unidade_controle.sv
// Moore FSM sequencing fetch/decode/execute/memory/write-back for the 8-bit multicycle CPU.
// Outputs are decoded straight from state_q so reset clears them without a clock edge.
module unidade_controle
    import controle_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    unidade_controle_if.master bus
);

    state_t     state_q, state_d;
    aluop_t     alu_op;
    logic [2:0] ula_control;
    logic       funct_illegal;
    logic       op_illegal;

    logic       ula_src_a;
    logic [1:0] ula_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       ior_d;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       ilegal;

    ula_decoder u_ula_decoder (
        .alu_op        (alu_op),
        .funct         (bus.Funct),
        .ula_control   (ula_control),
        .funct_illegal (funct_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RESET;
        else        state_q <= state_d;
    end

    assign op_illegal = !(bus.Op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});

    always_comb begin
        state_d    = state_q;
        alu_op     = ALUOP_ADD;
        ula_src_a  = 1'b0;
        ula_src_b  = SRCB_REGB;
        pc_src     = PCSRC_ALU;
        pc_en      = 1'b0;
        ior_d      = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        ilegal     = 1'b0;

        unique case (state_q)
            S_RESET: state_d = FETCH;
            FETCH: begin
                ir_write  = 1'b1;
                ula_src_b = SRCB_ONE;
                pc_en     = 1'b1;
                state_d   = DECODE;
            end
            // The ALU is otherwise idle here, so it precomputes PC + offset for beq
            DECODE: begin
                ula_src_b = SRCB_IMM;
                ilegal    = op_illegal;
                unique case (bus.Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEXEC;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                ula_src_a = 1'b1;
                ula_src_b = SRCB_IMM;
                state_d   = (bus.Op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                ior_d   = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                ior_d     = 1'b1;
                mem_write = 1'b1;
                state_d   = FETCH;
            end
            EXECUTE: begin
                ula_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
                ilegal    = funct_illegal;
                state_d   = funct_illegal ? FETCH : ALUWB;
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                ula_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_en     = bus.Z;
                state_d   = FETCH;
            end
            ADDIEXEC: begin
                ula_src_a = 1'b1;
                ula_src_b = SRCB_IMM;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            JUMP: begin
                pc_src  = PCSRC_JUMP;
                pc_en   = 1'b1;
                state_d = FETCH;
            end
            default: state_d = S_RESET;
        endcase
    end

    assign bus.UlaControl = ula_control;
    assign bus.UlaSrcA    = ula_src_a;
    assign bus.UlaSrcB    = ula_src_b;
    assign bus.PCSrc      = pc_src;
    assign bus.PCEn       = pc_en;
    assign bus.IorD       = ior_d;
    assign bus.MemWrite   = mem_write;
    assign bus.IRWrite    = ir_write;
    assign bus.RegWrite   = reg_write;
    assign bus.RegDst     = reg_dst;
    assign bus.MemtoReg   = mem_to_reg;
    assign bus.Ilegal     = ilegal;

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: directed instruction scenarios plus a random
// instruction stream, all compared cycle by cycle against an instruction-level output model.
module tb_unidade_controle;

    typedef logic [15:0] trace_t [0:7];

    logic clk;
    logic rst_n;
    int   n_compared;
    int   n_mismatched;

    unidade_controle_if bus ();

    unidade_controle dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Packed view of every output: {UlaControl, UlaSrcA, UlaSrcB, PCSrc, PCEn, IorD,
    // MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, Ilegal}
    logic [15:0] obs_vec;
    assign obs_vec = {bus.UlaControl, bus.UlaSrcA, bus.UlaSrcB, bus.PCSrc, bus.PCEn,
                      bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.RegDst,
                      bus.MemtoReg, bus.Ilegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mk(logic [2:0] ula, logic srca, logic [1:0] srcb,
                                       logic [1:0] pcsrc, logic pcen, logic iord,
                                       logic memw, logic irw, logic regw, logic regdst,
                                       logic memtoreg, logic ileg);
        return {ula, srca, srcb, pcsrc, pcen, iord, memw, irw, regw, regdst, memtoreg, ileg};
    endfunction

    function automatic int funct_code(logic [5:0] funct);
        case (funct)
            6'b100000: return 0;
            6'b100010: return 1;
            6'b100100: return 2;
            6'b100101: return 3;
            6'b101010: return 5;
            default:   return -1;
        endcase
    endfunction

    function automatic int exp_len(logic [5:0] op, logic [5:0] funct);
        case (op)
            6'b000000: return (funct_code(funct) < 0) ? 3 : 4;
            6'b100011: return 5;
            6'b101011: return 4;
            6'b000100: return 3;
            6'b001000: return 4;
            6'b000010: return 3;
            default:   return 2;
        endcase
    endfunction

    // Expected outputs in cycle k (0 = FETCH) of an instruction; past its end it is FETCH again
    function automatic logic [15:0] exp_cycle(logic [5:0] op, logic [5:0] funct, logic z, int k);
        logic [15:0] fetch_v;
        logic        known;
        int          code;
        fetch_v = mk(3'd0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        known   = (exp_len(op, funct) != 2);
        code    = funct_code(funct);
        if (k == 0 || k >= exp_len(op, funct)) return fetch_v;
        if (k == 1) return mk(3'd0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, !known);
        case (op)
            6'b000000: begin
                if (code < 0) return mk(3'd0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                if (k == 2)   return mk(3'(code), 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                return mk(3'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            end
            6'b100011, 6'b101011: begin
                if (k == 2) return mk(3'd0, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                if (k == 3) return mk(3'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, (op == 6'b101011), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                return mk(3'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            end
            6'b000100: return mk(3'b001, 1'b1, 2'b00, 2'b01, z, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            6'b001000: begin
                if (k == 2) return mk(3'd0, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                return mk(3'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            end
            default: return mk(3'd0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        endcase
    endfunction

    // Drives one instruction from FETCH and records outputs for cycles 0..n (n = next FETCH).
    // Z is randomised everywhere except the BRANCH cycle, where it takes the requested value.
    task automatic capture_instr(input logic [5:0] op, input logic [5:0] funct, input logic z,
                                 input int n, output trace_t obs);
        bus.Op    = op;
        bus.Funct = funct;
        for (int k = 0; k <= n; k++) begin
            bus.Z = (op == 6'b000100 && k == 2) ? z : 1'($urandom);
            #1;
            obs[k] = obs_vec;
            if (k < n) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.Op    = 6'b000000;
        bus.Funct = 6'b000000;
        bus.Z     = 1'b0;
        #1;
        n_compared++;
        if (obs_vec !== 16'h0000) begin
            n_mismatched++;
            $display("[TB] FAIL reset_async: got %h expected %h", obs_vec, 16'h0000);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        n_compared++;
        if (obs_vec !== 16'h0000) begin
            n_mismatched++;
            $display("[TB] FAIL reset_hold_state: got %h expected %h", obs_vec, 16'h0000);
        end
        @(posedge clk);
        #1;
        n_compared++;
        if (obs_vec !== exp_cycle(6'b000000, 6'b100000, 1'b0, 0)) begin
            n_mismatched++;
            $display("[TB] FAIL reset_to_fetch: got %h expected %h", obs_vec,
                     exp_cycle(6'b000000, 6'b100000, 1'b0, 0));
        end
    endtask

    task automatic test_add();
        trace_t obs;
        int     n;
        n = exp_len(6'b000000, 6'b100000);
        capture_instr(6'b000000, 6'b100000, 1'b0, n, obs);
        for (int k = 0; k <= n; k++) begin
            n_compared++;
            if (obs[k] !== exp_cycle(6'b000000, 6'b100000, 1'b0, k)) begin
                n_mismatched++;
                $display("[TB] FAIL add cycle %0d: got %h expected %h", k + 1, obs[k],
                         exp_cycle(6'b000000, 6'b100000, 1'b0, k));
            end
        end
    endtask

    task automatic test_funct_sweep();
        logic [5:0] functs [5] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        trace_t     obs;
        int         n;
        foreach (functs[i]) begin
            n = exp_len(6'b000000, functs[i]);
            capture_instr(6'b000000, functs[i], 1'b0, n, obs);
            for (int k = 0; k <= n; k++) begin
                n_compared++;
                if (obs[k] !== exp_cycle(6'b000000, functs[i], 1'b0, k)) begin
                    n_mismatched++;
                    $display("[TB] FAIL funct_%b cycle %0d: got %h expected %h", functs[i], k + 1,
                             obs[k], exp_cycle(6'b000000, functs[i], 1'b0, k));
                end
            end
        end
    endtask

    task automatic test_mem_ops();
        logic [5:0] ops [2] = '{6'b100011, 6'b101011};
        trace_t     obs;
        int         n;
        foreach (ops[i]) begin
            n = exp_len(ops[i], 6'b000000);
            capture_instr(ops[i], 6'($urandom), 1'b0, n, obs);
            for (int k = 0; k <= n; k++) begin
                n_compared++;
                if (obs[k] !== exp_cycle(ops[i], 6'b000000, 1'b0, k)) begin
                    n_mismatched++;
                    $display("[TB] FAIL mem_op_%b cycle %0d: got %h expected %h", ops[i], k + 1,
                             obs[k], exp_cycle(ops[i], 6'b000000, 1'b0, k));
                end
            end
        end
    endtask

    task automatic test_beq();
        trace_t obs;
        for (int zi = 1; zi >= 0; zi--) begin
            capture_instr(6'b000100, 6'b000000, 1'(zi), 3, obs);
            for (int k = 0; k <= 3; k++) begin
                n_compared++;
                if (obs[k] !== exp_cycle(6'b000100, 6'b000000, 1'(zi), k)) begin
                    n_mismatched++;
                    $display("[TB] FAIL beq_z%0d cycle %0d: got %h expected %h", zi, k + 1,
                             obs[k], exp_cycle(6'b000100, 6'b000000, 1'(zi), k));
                end
            end
        end
        // PCEn must track a glitching Z combinationally inside BRANCH
        bus.Op = 6'b000100;
        repeat (2) @(posedge clk);
        #1 bus.Z = 1'b0;
        #1;
        n_compared++;
        if (bus.PCEn !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL beq_glitch_low: got %b expected 0", bus.PCEn);
        end
        bus.Z = 1'b1;
        #1;
        n_compared++;
        if (bus.PCEn !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL beq_glitch_high: got %b expected 1", bus.PCEn);
        end
        @(posedge clk);
        #1;
        n_compared++;
        if (obs_vec !== exp_cycle(6'b000100, 6'b000000, 1'b1, 0)) begin
            n_mismatched++;
            $display("[TB] FAIL beq_glitch_return: got %h expected %h", obs_vec,
                     exp_cycle(6'b000100, 6'b000000, 1'b1, 0));
        end
    endtask

    task automatic test_other_ops();
        logic [5:0] ops [3] = '{6'b001000, 6'b000010, 6'b111111};
        trace_t     obs;
        int         n;
        foreach (ops[i]) begin
            n = exp_len(ops[i], 6'b000000);
            capture_instr(ops[i], 6'b000000, 1'b0, n, obs);
            for (int k = 0; k <= n; k++) begin
                n_compared++;
                if (obs[k] !== exp_cycle(ops[i], 6'b000000, 1'b0, k)) begin
                    n_mismatched++;
                    $display("[TB] FAIL op_%b cycle %0d: got %h expected %h", ops[i], k + 1,
                             obs[k], exp_cycle(ops[i], 6'b000000, 1'b0, k));
                end
            end
        end
    endtask

    task automatic test_reset_mid_memread();
        bus.Op = 6'b100011;
        repeat (3) @(posedge clk);
        #1;
        n_compared++;
        if (obs_vec !== exp_cycle(6'b100011, 6'b000000, 1'b0, 3)) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_memread: got %h expected %h", obs_vec,
                     exp_cycle(6'b100011, 6'b000000, 1'b0, 3));
        end
        #2 rst_n = 1'b0;
        #1;
        n_compared++;
        if (obs_vec !== 16'h0000) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_async_clear: got %h expected %h", obs_vec, 16'h0000);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        n_compared++;
        if (obs_vec !== 16'h0000) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_sreset_cycle: got %h expected %h", obs_vec, 16'h0000);
        end
        @(posedge clk);
        #1;
        n_compared++;
        if (obs_vec !== exp_cycle(6'b100011, 6'b000000, 1'b0, 0)) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_fetch: got %h expected %h", obs_vec,
                     exp_cycle(6'b100011, 6'b000000, 1'b0, 0));
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] legal_ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
        logic [5:0] functs [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        trace_t     obs;
        logic [5:0] op;
        logic [5:0] funct;
        logic       z;
        int         n;
        for (int i = 0; i < 40; i++) begin
            op    = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 5)];
            funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : functs[$urandom_range(0, 5)];
            z     = 1'($urandom);
            n     = exp_len(op, funct);
            capture_instr(op, funct, z, n, obs);
            for (int k = 0; k <= n; k++) begin
                n_compared++;
                if (obs[k] !== exp_cycle(op, funct, z, k)) begin
                    n_mismatched++;
                    $display("[TB] FAIL random_%0d op=%b funct=%b z=%b cycle %0d: got %h expected %h",
                             i, op, funct, z, k + 1, obs[k], exp_cycle(op, funct, z, k));
                end
            end
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        test_reset();
        test_add();
        test_funct_sweep();
        test_mem_ops();
        test_beq();
        test_other_ops();
        test_reset_mid_memread();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multicycle control unit for the 8-bit processor: a Moore FSM that sequences fetch, decode, execute, memory and write-back, and drives `UlaControl` plus the datapath multiplexer selects and write enables. It is the initiating end of the ALU interface. It issues the ALU operation codes and consumes the ALU's `Z` flag to resolve branches. It sits between the instruction register and the datapath (PC, memory, register file, ALU).

## Interface
- No parameters.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous reset, active-low.
- `Op` input 6: opcode field from the instruction register; valid from DECODE onward.
- `Funct` input 6: function field from the instruction register; used only for R-type.
- `Z` input 1: ALU zero flag; sampled combinationally in BRANCH.
- `UlaControl` output 3: ALU operation code.
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT.
- `UlaSrcA` output 1: ALU A-operand select; 0 PC, 1 register A.
- `UlaSrcB` output 2: ALU B-operand select.
  - 00 register B, 01 constant 1, 10 immediate, 11 reserved (never driven).
- `PCSrc` output 2: next-PC select; 00 ALU result, 01 ALUOut register, 10 jump target.
- `PCEn` output 1: PC write enable.
- `IorD` output 1: memory address select; 0 PC, 1 ALUOut.
- `MemWrite` output 1: data memory write enable.
- `IRWrite` output 1: instruction register load.
- `RegWrite` output 1: register file write enable.
- `RegDst` output 1: destination register select; 1 rd, 0 rt.
- `MemtoReg` output 1: write-back data select; 1 memory data, 0 ALUOut.
- `Ilegal` output 1: one-cycle pulse when an undefined opcode or funct is detected.

## Operation
- Opcodes:
  - R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- R-type funct to `UlaControl`:
  - add 100000 → 000, sub 100010 → 001, and 100100 → 010, or 100101 → 011, slt 101010 → 101.
- States: S_RESET, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
- Per-state outputs. Every output not listed is 0, and `UlaControl` defaults to 000.
  - S_RESET: all outputs 0.
  - FETCH: IRWrite=1, UlaSrcA=0, UlaSrcB=01, ADD, PCSrc=00, PCEn=1.
  - DECODE: UlaSrcA=0, UlaSrcB=10, ADD (precomputes the branch target).
  - MEMADR: UlaSrcA=1, UlaSrcB=10, ADD.
  - MEMREAD: IorD=1.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
  - MEMWRITE: IorD=1, MemWrite=1.
  - EXECUTE: UlaSrcA=1, UlaSrcB=00, `UlaControl` decoded from `Funct`.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1.
  - BRANCH: UlaSrcA=1, UlaSrcB=00, SUB, PCSrc=01, PCEn=Z.
  - ADDIEXEC: UlaSrcA=1, UlaSrcB=10, ADD.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
  - JUMP: PCSrc=10, PCEn=1.
- Transitions:
  - S_RESET → FETCH → DECODE.
  - DECODE by opcode: lw/sw → MEMADR, R-type → EXECUTE, beq → BRANCH, addi → ADDIEXEC, j → JUMP, other → FETCH.
  - MEMADR → MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD → MEMWB → FETCH; MEMWRITE → FETCH.
  - EXECUTE → ALUWB → FETCH, or EXECUTE → FETCH when the funct is undefined.
  - BRANCH, ADDIEXEC → ADDIWB, ADDIWB and JUMP all return to FETCH.
- Illegal opcode:
  - `Ilegal`=1 during DECODE, then FETCH.
  - No write enable is asserted for that instruction.
- Illegal funct:
  - `Ilegal`=1 during EXECUTE, with `UlaControl`=000.
  - Next state is FETCH; ALUWB is skipped, so there is no register write.

## Timing
- Cycles per instruction, counted from FETCH: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3.
- Outputs are pure functions of the state register. The only exceptions are `PCEn` in BRANCH, which follows `Z`, and the decoder outputs in EXECUTE and DECODE, which follow `Funct`/`Op`. There is no output register stage.
- Reset:
  - `rst_n`=0 forces S_RESET asynchronously, from any state including mid-instruction. All outputs go to 0 without waiting for a clock edge.
  - The first rising edge after `rst_n` rises moves S_RESET → FETCH.
- `Z` is a don't-care outside BRANCH.
- A `Z` glitch in BRANCH is tolerated: only its value at the closing edge matters.
- `Op`/`Funct` must be stable from the edge that ends FETCH until the instruction returns to FETCH. The IR is loaded only in FETCH.

## Structure
- Shared package `controle_pkg` contains:
  - the state enum;
  - opcode and funct constants;
  - `UlaControl` code constants (ADD/SUB/AND/OR/SLT), shared with the ALU;
  - `UlaSrcB` and `PCSrc` encodings.
- Sub-module `ula_decoder`: combinational. It maps a 2-bit ALUOp (00 ADD, 01 SUB, 10 funct) plus `Funct` to `UlaControl` and an illegal-funct flag.
- The FSM drives ALUOp per state.

## Test plan
- Reset, then add (Op=000000, Funct=100000):
  - States run FETCH, DECODE, EXECUTE, ALUWB.
  - `UlaControl`=000 in EXECUTE; RegWrite=1 and RegDst=1 only in cycle 4; back in FETCH on cycle 5.
- Funct sweep sub/and/or/slt:
  - `UlaControl`=001/010/011/101 in EXECUTE.
  - Funct=000000 → `Ilegal`=1 in EXECUTE, no RegWrite, next state FETCH.
- lw (100011):
  - Lasts 5 cycles.
  - IorD=1 in cycle 4; MemtoReg=1 and RegWrite=1 in cycle 5.
- sw (101011):
  - Lasts 4 cycles.
  - MemWrite=1 only in cycle 4.
- beq (000100):
  - With Z=1: PCEn=1 and PCSrc=01 in cycle 3.
  - With Z=0: PCEn=0 in cycle 3.
  - Both cases return to FETCH.
- Opcode 111111 → `Ilegal`=1 in DECODE, next state FETCH, zero write enables.
- rst_n=0 asserted mid-MEMREAD:
  - All outputs are 0 immediately, with no clock edge.
  - After release, one S_RESET cycle, then FETCH with IRWrite=1.
